forwarding: RTL and testbench

FORWARDING -- requirements
Module: forwarding

---
 rtl/forwarding_pkg.sv | 37 +++
 rtl/forwarding_if.sv | 23 ++
 rtl/forwarding_fwd_compare.sv | 24 ++
 rtl/forwarding.sv | 62 ++++++
 tb/tb_forwarding.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/forwarding_pkg.sv
// Shared definitions for operand forwarding. The pipeline control and the
// datapath muxes both use these select encodings and instruction field positions.
package forwarding_pkg;

  typedef enum logic [1:0] {
    FWD_MEM  = 2'b00,
    FWD_ALU  = 2'b01,
    FWD_RSVD = 2'b10,
    FWD_NONE = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_ALU  = 2'b01,
    CLS_LOAD = 2'b10
  } op_class_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 8;

  localparam logic [3:0] OPC_LOAD = 4'b1100;

  // Opcodes 0000-0111 write an ALU result; only 1100 writes load data.
  function automatic op_class_e decode_class(input logic [3:0] opc);
    op_class_e cls;
    cls = CLS_NONE;
    if (opc[3] == 1'b0) begin
      cls = CLS_ALU;
    end else if (opc == OPC_LOAD) begin
      cls = CLS_LOAD;
    end
    return cls;
  endfunction

endpackage

// File: rtl/forwarding_if.sv
// Bundle of the forwarding unit's pipeline-side signals. The master drives the
// buffer/writeback fields; the slave returns the two operand mux selects.
interface forwarding_if;
  import forwarding_pkg::*;

  logic [3:0]  op1_buf2;
  logic [3:0]  op2_buf2;
  logic [15:0] alu_out_buf3;
  logic [15:0] cntrl_wb;
  logic [1:0]  cntrl_m2;
  logic [1:0]  cntrl_m3;

  modport master (
    output op1_buf2, op2_buf2, alu_out_buf3, cntrl_wb,
    input  cntrl_m2, cntrl_m3
  );

  modport slave (
    input  op1_buf2, op2_buf2, alu_out_buf3, cntrl_wb,
    output cntrl_m2, cntrl_m3
  );

endinterface

// File: rtl/forwarding_fwd_compare.sv
// Forwarding select for one operand: compares its source address with the
// writeback destination and picks the source according to the writeback class.
module fwd_compare
  import forwarding_pkg::*;
(
  input  logic [3:0] src_addr,
  input  logic [3:0] dst_addr,
  input  op_class_e  op_class,
  output logic [1:0] sel
);

  // Register 0 is an ordinary register here; no zero-address exclusion.
  always_comb begin
    sel = FWD_NONE;
    if (src_addr == dst_addr) begin
      case (op_class)
        CLS_ALU:  sel = FWD_ALU;
        CLS_LOAD: sel = FWD_MEM;
        default:  sel = FWD_NONE;
      endcase
    end
  end

endmodule

// File: rtl/forwarding.sv
// Operand forwarding unit: evaluates both execute-stage operands against the
// writeback instruction and registers the two mux selects.
module forwarding
  import forwarding_pkg::*;
(
  input  logic [3:0]  in_op1_buf2,
  input  logic [3:0]  in_op2_buf2,
  input  logic [15:0] in_alu_out_buf3,
  input  logic [15:0] in_cntrl_wb,
  output logic [1:0]  out_cntrl_m2,
  output logic [1:0]  out_cntrl_m3,
  input  logic        CLOCK,
  input  logic        in_rst
);

  op_class_e  wb_class;
  logic [3:0] wb_dst;
  logic [1:0] cmp_m2;
  logic [1:0] cmp_m3;
  logic [1:0] cntrl_m2_d, cntrl_m2_q;
  logic [1:0] cntrl_m3_d, cntrl_m3_q;

  assign wb_class = decode_class(in_cntrl_wb[OPC_MSB:OPC_LSB]);
  assign wb_dst   = in_cntrl_wb[DST_MSB:DST_LSB];

  fwd_compare u_cmp_m2 (
    .src_addr (in_op1_buf2),
    .dst_addr (wb_dst),
    .op_class (wb_class),
    .sel      (cmp_m2)
  );

  fwd_compare u_cmp_m3 (
    .src_addr (in_op2_buf2),
    .dst_addr (wb_dst),
    .op_class (wb_class),
    .sel      (cmp_m3)
  );

  always_comb begin
    cntrl_m2_d = cmp_m2;
    cntrl_m3_d = cmp_m3;
  end

  always_ff @(posedge CLOCK or posedge in_rst) begin
    if (in_rst) begin
      cntrl_m2_q <= FWD_NONE;
      cntrl_m3_q <= FWD_NONE;
    end else begin
      cntrl_m2_q <= cntrl_m2_d;
      cntrl_m3_q <= cntrl_m3_d;
    end
  end

  assign out_cntrl_m2 = cntrl_m2_q;
  assign out_cntrl_m3 = cntrl_m3_q;

  // The ALU result and the writeback source fields pass by for the datapath only.
  logic unused_inputs;
  assign unused_inputs = ^{in_alu_out_buf3, in_cntrl_wb[7:0]};

endmodule

// File: tb/tb_forwarding.sv
// Bench for the forwarding unit: directed vector table, reset corner sequences
// and randomized traffic against a rule-level reference model.
module tb_forwarding;

  logic clk;
  logic rst;

  forwarding_if fif ();

  forwarding dut (
    .in_op1_buf2     (fif.op1_buf2),
    .in_op2_buf2     (fif.op2_buf2),
    .in_alu_out_buf3 (fif.alu_out_buf3),
    .in_cntrl_wb     (fif.cntrl_wb),
    .out_cntrl_m2    (fif.cntrl_m2),
    .out_cntrl_m3    (fif.cntrl_m3),
    .CLOCK           (clk),
    .in_rst          (rst)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [15:0] wb;
    logic [1:0]  m2;
    logic [1:0]  m3;
  } vec_t;

  vec_t tbl[12];

  // Scoreboard of pending expectations: {m2, m3} per applied edge.
  logic [3:0] exp_q[$];

  // ---------------- reference model ----------------
  // Straight from the rules: opcode < 8 writes an ALU result, opcode 12 loads,
  // anything else writes nothing; forward only when destination == source.
  function automatic logic [1:0] ref_sel(input int src, input int wb);
    int opc;
    int dst;
    opc = (wb / 4096) % 16;
    dst = (wb / 256) % 16;
    if (dst != src) return 2'd3;
    if (opc < 8)    return 2'd1;
    if (opc == 12)  return 2'd0;
    return 2'd3;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [1:0] m2_exp, input logic [1:0] m3_exp);
    n_vec++;
    if (fif.cntrl_m2 !== m2_exp || fif.cntrl_m3 !== m3_exp) begin
      n_err++;
      $display("FAIL %s: got m2=%b m3=%b, want m2=%b m3=%b",
               name, fif.cntrl_m2, fif.cntrl_m3, m2_exp, m3_exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] op1, input logic [3:0] op2, input logic [15:0] wb);
    fif.op1_buf2     = op1;
    fif.op2_buf2     = op2;
    fif.cntrl_wb     = wb;
    fif.alu_out_buf3 = 16'($urandom);
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic apply_edge(input logic [3:0] op1, input logic [3:0] op2, input logic [15:0] wb);
    @(negedge clk);
    drive(op1, op2, wb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] got;
    logic [3:0] op1, op2, dst;
    logic [15:0] wb;
    logic [3:0] opc_pick[6];

    tbl[0]  = '{4'h5, 4'h4, 16'h0464, 2'b11, 2'b01};
    tbl[1]  = '{4'h1, 4'h0, 16'hC120, 2'b00, 2'b11};
    tbl[2]  = '{4'h0, 4'h5, 16'h0455, 2'b11, 2'b11};
    tbl[3]  = '{4'h3, 4'h3, 16'h0300, 2'b01, 2'b01};
    tbl[4]  = '{4'h3, 4'h3, 16'hE300, 2'b11, 2'b11};
    tbl[5]  = '{4'h0, 4'h0, 16'h0000, 2'b01, 2'b01};
    tbl[6]  = '{4'h0, 4'h0, 16'hC000, 2'b00, 2'b00};
    tbl[7]  = '{4'hA, 4'h5, 16'h7A00, 2'b01, 2'b11};
    tbl[8]  = '{4'hA, 4'hA, 16'h8A00, 2'b11, 2'b11};
    tbl[9]  = '{4'hF, 4'hF, 16'hBF00, 2'b11, 2'b11};
    tbl[10] = '{4'h5, 4'h5, 16'hC5FF, 2'b00, 2'b00};
    tbl[11] = '{4'h3, 4'h4, 16'h1234, 2'b11, 2'b11};

    opc_pick[0] = 4'h0; opc_pick[1] = 4'h7; opc_pick[2] = 4'hC;
    opc_pick[3] = 4'h8; opc_pick[4] = 4'hD; opc_pick[5] = 4'hB;

    // Reset held from time 0: outputs must be 11 before any clock edge.
    rst = 1'b1;
    drive(4'h4, 4'h4, 16'h0400);
    #1;
    check("rst_async_start", 2'b11, 2'b11);

    // Reset held across toggling clock with matching inputs.
    for (int i = 0; i < 4; i++) begin
      apply_edge(4'($urandom), 4'h4, 16'h0400);
      check("rst_held", 2'b11, 2'b11);
    end

    // First edge after release loads the selects from the current inputs.
    @(negedge clk);
    drive(4'h5, 4'h4, 16'h0464);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_first_edge", 2'b11, 2'b01);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      apply_edge(tbl[i].op1, tbl[i].op2, tbl[i].wb);
      check($sformatf("table[%0d]", i), tbl[i].m2, tbl[i].m3);
    end

    // Input changes between edges must not reach the outputs.
    apply_edge(4'h3, 4'h3, 16'h0300);
    check("hold_before", 2'b01, 2'b01);
    #2;
    drive(4'h3, 4'h3, 16'hE300);
    #1;
    check("hold_mid_cycle", 2'b01, 2'b01);
    @(posedge clk);
    #1;
    check("hold_next_edge", 2'b11, 2'b11);

    // Reset asserted between edges forces 11 without a clock edge.
    apply_edge(4'h5, 4'h4, 16'h0464);
    check("pre_midreset", 2'b11, 2'b01);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_immediate", 2'b11, 2'b11);
    @(posedge clk);
    #1;
    check("midreset_held_edge", 2'b11, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_release", 2'b11, 2'b01);

    // Randomized traffic with occasional one-cycle resets.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      dst = 4'($urandom);
      wb  = {opc_pick[$urandom_range(0, 5)], dst, 8'($urandom)};
      if ($urandom_range(0, 3) == 0) wb[15:12] = 4'($urandom);
      op1 = ($urandom_range(0, 1) == 1) ? dst : 4'($urandom);
      op2 = ($urandom_range(0, 1) == 1) ? dst : 4'($urandom);
      drive(op1, op2, wb);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        exp_q.push_back(4'b1111);
      end else begin
        rst = 1'b0;
        exp_q.push_back({ref_sel(int'(op1), int'(wb)), ref_sel(int'(op2), int'(wb))});
      end
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check($sformatf("random[%0d]", i), got[3:2], got[1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
